// File: rtl/window_read_ctrl.sv
// Display-side read scheduler for the camera window: synchronises frame-ready, issues one FIFO read per window
// slot and emits a registered, underflow-filled pixel stream. Optional macro: WINDOW_UNDERFLOW_CNT_EN (starved-slot counter).
module window_read_ctrl #(
  parameter int WIN_X0      = 304,
  parameter int WIN_Y0      = 224,
  parameter int WIN_W       = 32,
  parameter int WIN_H       = 32,
  parameter int DATA_WIDTH  = 4,
  parameter int COORD_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] FILL_PIXEL = '0
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Frame_Ready,
  input  logic [COORD_WIDTH-1:0] i_X,
  input  logic [COORD_WIDTH-1:0] i_Y,
  input  logic                   i_Active,
  input  logic                   i_Empty,
  input  logic [DATA_WIDTH-1:0]  i_Data,
  output logic                   o_Rd_En,
  output logic [DATA_WIDTH-1:0]  o_Pixel,
  output logic                   o_Pixel_Valid,
  output logic                   o_Abort,
  output logic [15:0]            o_Underflow_Count,
  output logic [1:0]             o_State
);

  localparam int N_SLOTS = WIN_W * WIN_H;
  localparam int CNT_W   = $clog2(N_SLOTS) + 1;
  localparam logic [COORD_WIDTH-1:0] X_LO = COORD_WIDTH'(WIN_X0);
  localparam logic [COORD_WIDTH-1:0] X_HI = COORD_WIDTH'(WIN_X0 + WIN_W);
  localparam logic [COORD_WIDTH-1:0] Y_LO = COORD_WIDTH'(WIN_Y0);
  localparam logic [COORD_WIDTH-1:0] Y_HI = COORD_WIDTH'(WIN_Y0 + WIN_H);
  localparam logic [CNT_W-1:0]       LAST_SLOT = CNT_W'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             sync_q1, rdy_s, rdy_d;
  logic [1:0]       prime_q;
  logic             edge_ok, rdy_rise, rdy_fall;
  logic             is_slot, is_corner, last_slot;
  logic             stream_slot, abort_set;
  logic [CNT_W-1:0] slot_cnt;
  logic             slot_d1, fill_d1;

  // Edges are ignored until all three flops hold real samples, so a level
  // already high at reset release is never mistaken for a rising edge.
  // NOTE: sequential state uses non-blocking assignments with an async reset branch; blocking here would race against other flops.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q1 <= 1'b0;
      rdy_s   <= 1'b0;
      rdy_d   <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      sync_q1 <= i_Frame_Ready;
      rdy_s   <= sync_q1;
      rdy_d   <= rdy_s;
      if (prime_q != 2'd3) prime_q <= prime_q + 2'd1;
    end
  end

  assign edge_ok  = (prime_q == 2'd3);
  assign rdy_rise = edge_ok &  rdy_s & ~rdy_d;
  assign rdy_fall = edge_ok & ~rdy_s &  rdy_d;

  assign is_slot   = i_Active && (i_X >= X_LO) && (i_X < X_HI) && (i_Y >= Y_LO) && (i_Y < Y_HI);
  assign is_corner = is_slot && (i_X == X_LO) && (i_Y == Y_LO);
  assign last_slot = (slot_cnt == LAST_SLOT);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next  = state;
    stream_slot = 1'b0;
    abort_set   = 1'b0;
    case (state)
      IDLE: begin
        if (rdy_rise) state_next = ARMED;
      end
      ARMED: begin
        if (rdy_fall) begin
          state_next = IDLE;
        end else if (is_corner) begin
          // The corner slot is already the first streamed slot.
          stream_slot = 1'b1;
          state_next  = last_slot ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (rdy_fall) begin
          state_next = IDLE;
          abort_set  = 1'b1;
        end else if (is_slot) begin
          stream_slot = 1'b1;
          if (last_slot) state_next = DONE;
        end
      end
      DONE: begin
        if (rdy_fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_Rd_En = stream_slot & ~i_Empty;
  assign o_State = state;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                slot_cnt <= '0;
    else if (stream_slot)     slot_cnt <= slot_cnt + 1'b1;
    else if (state == IDLE)   slot_cnt <= '0;
  end

  // Two-stage output pipeline: stage 1 tracks the slot and whether it was
  // served, stage 2 merges in i_Data, which arrives one cycle after the read.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      slot_d1       <= 1'b0;
      fill_d1       <= 1'b0;
      o_Pixel_Valid <= 1'b0;
      o_Pixel       <= '0;
      o_Abort       <= 1'b0;
    end else begin
      slot_d1       <= is_slot;
      fill_d1       <= ~o_Rd_En;
      o_Pixel_Valid <= slot_d1;
      o_Pixel       <= slot_d1 ? (fill_d1 ? FILL_PIXEL : i_Data) : '0;
      o_Abort       <= abort_set;
    end
  end

`ifdef WINDOW_UNDERFLOW_CNT_EN
  logic        starved;
  logic [15:0] underflow_cnt;

  assign starved = stream_slot & i_Empty;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)                                        underflow_cnt <= 16'd0;
    else if (starved && (underflow_cnt != 16'hFFFF))  underflow_cnt <= underflow_cnt + 16'd1;
  end

  assign o_Underflow_Count = underflow_cnt;
`else
  assign o_Underflow_Count = 16'd0;
`endif

endmodule

// File: tb/tb_window_read_ctrl.sv
// Directed bench for window_read_ctrl: compressed raster frames around the window plus a
// table of decode/state vectors; expected counts follow WINDOW_UNDERFLOW_CNT_EN.
module tb_window_read_ctrl;

  logic        clk = 1'b0;
  logic        rst, frame_ready, active, empty, rd_en, pix_valid, abort;
  logic [9:0]  x, y;
  logic [3:0]  data, pixel;
  logic [15:0] uf_count;
  logic [1:0]  st;

  int errors = 0;
  int checks = 0;

`ifdef WINDOW_UNDERFLOW_CNT_EN
  localparam int UF_AFTER_UNDERFLOW = 10;
  localparam int UF_AFTER_TABLE     = 12;
`else
  localparam int UF_AFTER_UNDERFLOW = 0;
  localparam int UF_AFTER_TABLE     = 0;
`endif

  window_read_ctrl dut (
    .i_Clk             (clk),
    .i_Rst             (rst),
    .i_Frame_Ready     (frame_ready),
    .i_X               (x),
    .i_Y               (y),
    .i_Active          (active),
    .i_Empty           (empty),
    .i_Data            (data),
    .o_Rd_En           (rd_en),
    .o_Pixel           (pixel),
    .o_Pixel_Valid     (pix_valid),
    .o_Abort           (abort),
    .o_Underflow_Count (uf_count),
    .o_State           (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] vx;
    logic [9:0] vy;
    logic       vact;
    logic       vemp;
    logic       exp_rd;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[13];

  int         cyc = 0;
  int         fifo_idx = 0;
  logic       rd_now;
  int         n_rd, n_abort, abort_lat, pix_err, idle_aborts;
  int         first_x, first_y, last_x, last_y;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: inputs applied just after an edge, read strobe sampled before
  // the next edge, FIFO model answers a read with data one cycle later.
  task automatic cycle(input logic [9:0] cx, input logic [9:0] cy, input logic cact, input logic cemp);
    x = cx; y = cy; active = cact; empty = cemp;
    #1;
    rd_now = rd_en;
    @(posedge clk);
    #1;
    if (rd_now) begin
      data = 4'(fifo_idx % 16);
      fifo_idx++;
    end else begin
      data = 4'hA;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(10'd0, 10'd0, 1'b0, 1'b0);
      if (abort) idle_aborts++;
    end
  endtask

  task automatic arm();
    frame_ready = 1'b0;
    idle(6);
    frame_ready = 1'b1;
    idle(6);
  endtask

  // mode 0: full, 1: underflow at slots 100-109, 2: abort after slot 500, 3: not armed
  task automatic run_frame(input int mode);
    int         s = 0;
    int         exp_idx = 0;
    int         drop_cyc = 0;
    logic       pv_prev = 1'b0;
    logic [3:0] pp_prev = 4'd0;
    logic       win, emp, served;
    n_rd = 0; n_abort = 0; abort_lat = -1; pix_err = 0; fifo_idx = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    for (int yy = 220; yy < 260; yy++) begin
      for (int xx = 300; xx < 340; xx++) begin
        win = (xx >= 304) && (xx < 336) && (yy >= 224) && (yy < 256);
        if (mode == 2 && s > 500 && frame_ready) begin
          frame_ready = 1'b0;
          drop_cyc = cyc;
        end
        emp = (mode == 1) && win && (s >= 100) && (s <= 109);
        // Two synchroniser flops: the stream sees the drop on the third slot after it.
        served = win && ((mode == 0) || (mode == 1 && !emp) || (mode == 2 && s <= 502));
        cycle(10'(xx), 10'(yy), xx < 336, emp);
        if (rd_now) begin
          if (n_rd == 0) begin first_x = xx; first_y = yy; end
          last_x = xx; last_y = yy;
          n_rd++;
        end
        if (abort) begin
          n_abort++;
          abort_lat = cyc - drop_cyc;
        end
        if (pix_valid !== pv_prev || pixel !== pp_prev) pix_err++;
        pv_prev = win;
        pp_prev = served ? 4'(exp_idx % 16) : 4'd0;
        if (served) exp_idx++;
        if (win) s++;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{10'd304, 10'd225, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[1]  = '{10'd303, 10'd224, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[2]  = '{10'd304, 10'd224, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[3]  = '{10'd304, 10'd224, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[4]  = '{10'd304, 10'd224, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5]  = '{10'd335, 10'd224, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[6]  = '{10'd336, 10'd224, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[7]  = '{10'd310, 10'd223, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[8]  = '{10'd310, 10'd255, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[9]  = '{10'd310, 10'd256, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[10] = '{10'd303, 10'd230, 1'b1, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{10'd320, 10'd240, 1'b0, 1'b0, 1'b0, 2'd2};
    vecs[12] = '{10'd320, 10'd240, 1'b1, 1'b1, 1'b0, 2'd2};

    idle_aborts = 0;
    rst = 1'b1; frame_ready = 1'b1;
    x = '0; y = '0; active = 1'b0; empty = 1'b0; data = 4'h0;
    #23;
    check("reset_rd_en",     int'(rd_en),     0);
    check("reset_pixel",     int'(pixel),     0);
    check("reset_valid",     int'(pix_valid), 0);
    check("reset_abort",     int'(abort),     0);
    check("reset_underflow", int'(uf_count),  0);
    check("reset_state",     int'(st),        0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ready held high through reset release must not arm.
    idle(8);
    check("noarm_state", int'(st), 0);
    run_frame(3);
    check("noarm_reads", n_rd, 0);
    check("noarm_state_end", int'(st), 0);
    check("noarm_pixels", pix_err, 0);

    arm();
    check("armed_state", int'(st), 1);
    run_frame(0);
    check("full_reads", n_rd, 1024);
    check("full_first_x", first_x, 304);
    check("full_first_y", first_y, 224);
    check("full_last_x", last_x, 335);
    check("full_last_y", last_y, 255);
    check("full_state", int'(st), 3);
    check("full_underflow", int'(uf_count), 0);
    check("full_pixels", pix_err, 0);
    check("full_aborts", n_abort, 0);

    frame_ready = 1'b0;
    idle(6);
    check("done_to_idle_state", int'(st), 0);
    check("done_to_idle_abort", idle_aborts, 0);

    arm();
    run_frame(1);
    check("uf_reads", n_rd, 1014);
    check("uf_state", int'(st), 3);
    check("uf_count", int'(uf_count), UF_AFTER_UNDERFLOW);
    check("uf_pixels", pix_err, 0);
    check("uf_aborts", n_abort, 0);

    arm();
    run_frame(2);
    check("abort_reads", n_rd, 503);
    check("abort_pulses", n_abort, 1);
    check("abort_latency_ok", int'(abort_lat >= 1 && abort_lat <= 4), 1);
    check("abort_state", int'(st), 0);
    check("abort_pixels", pix_err, 0);

    arm();
    check("table_armed", int'(st), 1);
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].vx, vecs[i].vy, vecs[i].vact, vecs[i].vemp);
      check($sformatf("vec%0d_rd_en", i), int'(rd_now), int'(vecs[i].exp_rd));
      check($sformatf("vec%0d_state", i), int'(st), int'(vecs[i].exp_st));
    end
    idle(1);
    check("table_underflow", int'(uf_count), UF_AFTER_TABLE);

    // Reset in the middle of a stream discards it.
    #2;
    rst = 1'b1;
    #1;
    check("midreset_state", int'(st), 0);
    check("midreset_underflow", int'(uf_count), 0);
    check("midreset_rd_en", int'(rd_en), 0);
    idle(2);
    rst = 1'b0;
    idle(4);
    check("post_reset_state", int'(st), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
